// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the main-memory arbiter.
//   ADDR_W/DATA_W   : memory byte-address and data widths
//   BLOCK_WORDS     : 16-bit words per cache block (power of two)
//   WORD_W/OFFSET_W : word-index and byte-offset widths within a block
//   RR_RST_PREFER_IC: round-robin pointer reset value (0 = D-cache first)
package mem_arb_pkg;

   localparam int unsigned ADDR_W      = 16;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned BLOCK_WORDS = 8;
   localparam int unsigned WORD_W      = $clog2(BLOCK_WORDS);
   localparam int unsigned OFFSET_W    = WORD_W + 1;

   localparam logic RR_RST_PREFER_IC = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL_IC = 2'd1,
      ST_FILL_DC = 2'd2,
      ST_WRITE   = 2'd3
   } arb_state_e;

   // Memory request side payload
   typedef struct packed {
      logic              enable;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_req_t;

endpackage

// File: rtl/mem_arb_word_cnt.sv
// Block word counter used for both the read-issue and the read-return side.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : advance by one
//   clr        : synchronous clear (wins over en)
//   cnt        : current count
//   terminal_c : count is at its last value
module mem_arb_word_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned W = WORD_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         terminal_c
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + W'(1);
   end

   assign terminal_c = (cnt == {W{1'b1}});

endmodule

// File: rtl/mem_arbiter.sv
// Shared main-memory port arbiter: D-cache stores, D-cache fills, I-cache fills.
// Grants one requester, issues the block reads (or the single store), counts
// returning valid beats and steers valid/index/done to the granted cache.
// Option: define MEM_ARB_RR_EN for round-robin between the two fill requesters
// (stores always keep top priority); otherwise D-cache fills beat I-cache fills.
//   ic_req/ic_addr, dc_req/dc_addr       : fill requests, held until done
//   dc_wr_req/dc_wr_addr/dc_wr_data      : store request, held until dc_wr_ack
//   mem_data_valid                       : one returned read word
//   ic_grant/dc_grant                    : fill owns the memory port
//   ic_data_valid/dc_data_valid          : returned valid steered to the owner
//   fill_word                            : index of the returning word
//   ic_done/dc_done                      : pulse with the final returned word
//   dc_wr_ack                            : pulse while the store is on the port
//   mem_enable/mem_wr/mem_addr/mem_data_out : memory request side
module mem_arbiter
   import mem_arb_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   input  logic              dc_req,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic              dc_wr_req,
   input  logic [ADDR_W-1:0] dc_wr_addr,
   input  logic [DATA_W-1:0] dc_wr_data,
   input  logic              mem_data_valid,
   output logic              ic_grant,
   output logic              dc_grant,
   output logic              ic_data_valid,
   output logic              dc_data_valid,
   output logic [WORD_W-1:0] fill_word,
   output logic              ic_done,
   output logic              dc_done,
   output logic              dc_wr_ack,
   output logic              mem_enable,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data_out
);

   arb_state_e        state, state_nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              issue_done_q;
   logic [WORD_W-1:0] issue_cnt, rcv_cnt;
   logic              issue_last_c, rcv_last_c;
   logic              filling_c, issue_en_c, rcv_en_c, fill_end_c;
   logic              pick_ic_c, pick_dc_c;
   logic              load_c, load_wr_c;
   logic [ADDR_W-1:0] load_addr_c;
   mem_req_t          mem_req_c;

   // Fill arbitration between the two caches
`ifdef MEM_ARB_RR_EN
   logic prefer_ic_q;

   assign pick_dc_c = dc_req && !(ic_req && prefer_ic_q);

   // Pointer flips to the other cache whenever a fill is granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         prefer_ic_q <= RR_RST_PREFER_IC;
      else if (load_c && !load_wr_c)   prefer_ic_q <= (state_nxt == ST_FILL_DC);
   end
`else
   assign pick_dc_c = dc_req;
`endif
   assign pick_ic_c = ic_req && !pick_dc_c;

   assign filling_c  = (state == ST_FILL_IC) || (state == ST_FILL_DC);
   assign issue_en_c = filling_c && !issue_done_q;
   // Valid beats outside a fill are ignored entirely
   assign rcv_en_c   = filling_c && mem_data_valid;
   assign fill_end_c = rcv_en_c && rcv_last_c;

   mem_arb_word_cnt #(.W(WORD_W)) u_issue_cnt (
      .clk        (clk),
      .rst        (rst),
      .en         (issue_en_c),
      .clr        (fill_end_c),
      .cnt        (issue_cnt),
      .terminal_c (issue_last_c)
   );

   mem_arb_word_cnt #(.W(WORD_W)) u_rcv_cnt (
      .clk        (clk),
      .rst        (rst),
      .en         (rcv_en_c),
      .clr        (fill_end_c),
      .cnt        (rcv_cnt),
      .terminal_c (rcv_last_c)
   );

   // State register, request latches and issue-complete flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         addr_q       <= '0;
         data_q       <= '0;
         issue_done_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load_c)    addr_q <= load_addr_c;
         if (load_wr_c) data_q <= dc_wr_data;
         // The issue counter wraps after the last read; this flag stops further issues
         if (fill_end_c)                      issue_done_q <= 1'b0;
         else if (issue_en_c && issue_last_c) issue_done_q <= 1'b1;
      end
   end

   // Next-state and request capture
   always_comb begin
      state_nxt   = state;
      load_c      = 1'b0;
      load_wr_c   = 1'b0;
      load_addr_c = ic_addr;
      case (state)
         ST_IDLE: begin
            if (dc_wr_req) begin
               state_nxt   = ST_WRITE;
               load_c      = 1'b1;
               load_wr_c   = 1'b1;
               load_addr_c = dc_wr_addr;
            end else if (pick_dc_c) begin
               state_nxt   = ST_FILL_DC;
               load_c      = 1'b1;
               load_addr_c = dc_addr;
            end else if (pick_ic_c) begin
               state_nxt   = ST_FILL_IC;
               load_c      = 1'b1;
               load_addr_c = ic_addr;
            end
         end
         ST_FILL_IC, ST_FILL_DC: begin
            if (fill_end_c) state_nxt = ST_IDLE;
         end
         ST_WRITE: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Memory request side
   always_comb begin
      mem_req_c = '0;
      if (state == ST_WRITE) begin
         mem_req_c.enable = 1'b1;
         mem_req_c.wr     = 1'b1;
         mem_req_c.addr   = addr_q;
         mem_req_c.data   = data_q;
      end else if (issue_en_c) begin
         mem_req_c.enable = 1'b1;
         mem_req_c.addr   = {addr_q[ADDR_W-1:OFFSET_W], issue_cnt, 1'b0};
      end
   end

   assign mem_enable    = mem_req_c.enable;
   assign mem_wr        = mem_req_c.wr;
   assign mem_addr      = mem_req_c.addr;
   assign mem_data_out  = mem_req_c.data;

   assign ic_grant      = (state == ST_FILL_IC);
   assign dc_grant      = (state == ST_FILL_DC);
   assign ic_data_valid = rcv_en_c && (state == ST_FILL_IC);
   assign dc_data_valid = rcv_en_c && (state == ST_FILL_DC);
   assign ic_done       = fill_end_c && (state == ST_FILL_IC);
   assign dc_done       = fill_end_c && (state == ST_FILL_DC);
   assign fill_word     = rcv_cnt;
   assign dc_wr_ack     = (state == ST_WRITE);

endmodule
